// File: rtl/servant_gpio_pkg.sv
// rtl/servant_gpio_pkg.sv - shared constants and types for the servant GPIO bank
package servant_gpio_pkg;

  localparam int WB_DW = 32;

  localparam logic [2:0] GPIO_OUT     = 3'd0;
  localparam logic [2:0] GPIO_OE      = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_RISE_EN = 3'd3;
  localparam logic [2:0] GPIO_FALL_EN = 3'd4;
  localparam logic [2:0] GPIO_STATUS  = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR = 3'd7;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/servant_gpio_bank_if.sv
// rtl/servant_gpio_bank_if.sv - Wishbone slave bus bundle for the GPIO bank
interface servant_gpio_bank_if;
  import servant_gpio_pkg::*;

  logic [2:0]       i_wb_adr;
  logic [WB_DW-1:0] i_wb_dat;
  logic             i_wb_we;
  logic             i_wb_cyc;
  logic             i_wb_stb;
  logic [WB_DW-1:0] o_wb_rdt;
  logic             o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );

endinterface

// File: rtl/servant_gpio_sync.sv
// rtl/servant_gpio_sync.sv - WIDTH-bit multi-stage input synchroniser
module servant_gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // chain[0] samples the pin; chain[SYNC_STAGES-1] is the settled value
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/servant_gpio_bank.sv
// rtl/servant_gpio_bank.sv - Wishbone GPIO bank with edge-detect interrupts
module servant_gpio_bank
  import servant_gpio_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic OUT_RESET   = 1'b1
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  servant_gpio_bank_if.slave   wb,
  input  logic [WIDTH-1:0]     i_gpio,
  output logic [WIDTH-1:0]     o_gpio,
  output logic [WIDTH-1:0]     o_gpio_oe,
  output logic                 o_irq
);

  localparam int ARM_CYC = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);

  bus_state_e       state_q, state_d;
  logic             start;
  logic             wr_en;
  logic [WB_DW-1:0] rd_word;
  logic [WB_DW-1:0] rdt_q;

  logic [WIDTH-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [WIDTH-1:0] sync, prev;
  logic [WIDTH-1:0] wdat, status_clr, edge_ev;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic             irq_q;
  logic             unused_dat;

  assign wdat       = wb.i_wb_dat[WIDTH-1:0];
  assign unused_dat = ^wb.i_wb_dat;

  servant_gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (wb_clk),
    .rst (wb_rst),
    .d   (i_gpio),
    .q   (sync)
  );

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= BUS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read data is captured on the request edge; writes commit on the edge that ends ack
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      BUS_IDLE: begin
        if (wb.i_wb_cyc && wb.i_wb_stb) begin
          state_d = BUS_ACK;
          start   = 1'b1;
        end
      end
      BUS_ACK: begin
        state_d = BUS_IDLE;
        wr_en   = wb.i_wb_cyc && wb.i_wb_stb && wb.i_wb_we;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (wb.i_wb_adr)
      GPIO_OUT:     rd_word[WIDTH-1:0] = out_q;
      GPIO_OE:      rd_word[WIDTH-1:0] = oe_q;
      GPIO_IN:      rd_word[WIDTH-1:0] = sync;
      GPIO_RISE_EN: rd_word[WIDTH-1:0] = rise_en_q;
      GPIO_FALL_EN: rd_word[WIDTH-1:0] = fall_en_q;
      GPIO_STATUS:  rd_word[WIDTH-1:0] = status_q;
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rdt_q <= '0;
    end else begin
      rdt_q <= start ? rd_word : '0;
    end
  end

  assign wb.o_wb_ack = (state_q == BUS_ACK);
  assign wb.o_wb_rdt = rdt_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      out_q     <= {WIDTH{OUT_RESET}};
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (wb.i_wb_adr)
        GPIO_OUT:     out_q     <= wdat;
        GPIO_OE:      oe_q      <= wdat;
        GPIO_RISE_EN: rise_en_q <= wdat;
        GPIO_FALL_EN: fall_en_q <= wdat;
        GPIO_OUT_SET: out_q     <= out_q | wdat;
        GPIO_OUT_CLR: out_q     <= out_q & ~wdat;
        default: ;
      endcase
    end
  end

  // Detection stays off until the zeroed chain and prev hold real pin values
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      arm_cnt <= '0;
      prev    <= '0;
    end else begin
      prev <= sync;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end
    end
  end

  assign armed      = (arm_cnt == ARM_W'(ARM_CYC));
  assign edge_ev    = armed ? ((sync & ~prev & rise_en_q) | (~sync & prev & fall_en_q)) : '0;
  assign status_clr = (wr_en && wb.i_wb_adr == GPIO_STATUS) ? wdat : '0;

  // A new edge in the same cycle as its W1C keeps the bit set
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~status_clr) | edge_ev;
      irq_q    <= |status_q;
    end
  end

  assign o_gpio    = out_q;
  assign o_gpio_oe = oe_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_servant_gpio_bank.sv
// tb/tb_servant_gpio_bank.sv - self-checking bench for servant_gpio_bank
module tb_servant_gpio_bank;
  import servant_gpio_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int BIT_CYC = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  servant_gpio_bank_if bus ();
  servant_gpio_bank_if bus1 ();

  logic [W-1:0] pins, gpio, gpio_oe;
  logic         irq;
  logic [0:0]   pin1, gpio1, gpio1_oe;
  logic         irq1;

  servant_gpio_bank #(.WIDTH(W), .SYNC_STAGES(SS), .OUT_RESET(1'b1)) dut (
    .wb_clk(clk), .wb_rst(rst), .wb(bus.slave),
    .i_gpio(pins), .o_gpio(gpio), .o_gpio_oe(gpio_oe), .o_irq(irq)
  );

  servant_gpio_bank #(.WIDTH(1), .SYNC_STAGES(SS), .OUT_RESET(1'b1)) dut1 (
    .wb_clk(clk), .wb_rst(rst), .wb(bus1.slave),
    .i_gpio(pin1), .o_gpio(gpio1), .o_gpio_oe(gpio1_oe), .o_irq(irq1)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_out, m_oe, m_in, m_rise, m_fall, m_status;

  task automatic bus_xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                          output logic [31:0] rdt);
    logic got;
    got = 1'b0;
    rdt = '0;
    bus.i_wb_adr = adr; bus.i_wb_we = we; bus.i_wb_dat = dat;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.o_wb_ack) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL bus_ack_timeout adr=%0d ack=0 required=1", adr);
    end else rdt = bus.o_wb_rdt;
    @(posedge clk); #1;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
  endtask

  task automatic bus1_xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                           output logic [31:0] rdt);
    logic got;
    got = 1'b0;
    rdt = '0;
    bus1.i_wb_adr = adr; bus1.i_wb_we = we; bus1.i_wb_dat = dat;
    bus1.i_wb_cyc = 1'b1; bus1.i_wb_stb = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus1.o_wb_ack) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL bus1_ack_timeout adr=%0d ack=0 required=1", adr);
    end else rdt = bus1.o_wb_rdt;
    @(posedge clk); #1;
    bus1.i_wb_cyc = 1'b0; bus1.i_wb_stb = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: exp_rd = {24'd0, m_out};
      3'd1: exp_rd = {24'd0, m_oe};
      3'd2: exp_rd = {24'd0, m_in};
      3'd3: exp_rd = {24'd0, m_rise};
      3'd4: exp_rd = {24'd0, m_fall};
      3'd5: exp_rd = {24'd0, m_status};
      default: exp_rd = 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    pins = 8'hA5; pin1 = 1'b0;
    bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0; bus.i_wb_adr = 0; bus.i_wb_dat = 0;
    bus1.i_wb_cyc = 0; bus1.i_wb_stb = 0; bus1.i_wb_we = 0; bus1.i_wb_adr = 0; bus1.i_wb_dat = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gpio !== 8'hFF) begin failures++; $display("FAIL reset_out got=%h required=ff", gpio); end
    checks++; if (gpio_oe !== 8'h00) begin failures++; $display("FAIL reset_oe got=%h required=00", gpio_oe); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b required=0", irq); end
    checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_wb_rdt !== 32'd0) begin
      failures++; $display("FAIL reset_bus ack=%b rdt=%h required ack=0 rdt=0", bus.o_wb_ack, bus.o_wb_rdt);
    end
    // enable every edge straight after release: a zeroed synchroniser must not look like a rise
    rst = 1'b0;
    bus_xfer(GPIO_RISE_EN, 1'b1, 32'hFF, r);
    bus_xfer(GPIO_FALL_EN, 1'b1, 32'hFF, r);
    bus_xfer(GPIO_STATUS, 1'b0, 32'd0, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL reset_no_spurious_edge got=%h required=0", r); end
    bus_xfer(GPIO_IN, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h000000A5) begin failures++; $display("FAIL reset_in got=%h required=000000a5", r); end
    bus_xfer(GPIO_OUT, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h000000FF) begin failures++; $display("FAIL reset_out_read got=%h required=000000ff", r); end
    bus_xfer(GPIO_RISE_EN, 1'b1, 32'h0, r);
    bus_xfer(GPIO_FALL_EN, 1'b1, 32'h0, r);
  endtask

  task automatic test_bus();
    logic [31:0] r;
    bus_xfer(GPIO_OUT, 1'b1, 32'hFFFF_FF3C, r);
    checks++; if (bus.o_wb_ack !== 1'b0 || bus.o_wb_rdt !== 32'd0) begin
      failures++; $display("FAIL ack_one_cycle ack=%b rdt=%h required ack=0 rdt=0", bus.o_wb_ack, bus.o_wb_rdt);
    end
    bus_xfer(GPIO_OUT, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h3C) begin failures++; $display("FAIL out_write got=%h required=3c", r); end
    bus_xfer(GPIO_OUT_SET, 1'b1, 32'h01, r);
    bus_xfer(GPIO_OUT, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h3D) begin failures++; $display("FAIL out_set got=%h required=3d", r); end
    bus_xfer(GPIO_OUT_CLR, 1'b1, 32'h0C, r);
    bus_xfer(GPIO_OUT, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h31) begin failures++; $display("FAIL out_clr got=%h required=31", r); end
    checks++; if (gpio !== 8'h31) begin failures++; $display("FAIL out_pins got=%h required=31", gpio); end
    bus_xfer(GPIO_OUT_SET, 1'b0, 32'd0, r);
    checks++; if (r !== 32'd0) begin failures++; $display("FAIL out_set_read got=%h required=0", r); end
    bus_xfer(GPIO_IN, 1'b1, 32'h0, r);
    bus_xfer(GPIO_IN, 1'b0, 32'd0, r);
    checks++; if (r !== 32'hA5) begin failures++; $display("FAIL in_readonly got=%h required=a5", r); end
  endtask

  task automatic test_back_to_back();
    bus.i_wb_adr = GPIO_OUT; bus.i_wb_we = 1'b0; bus.i_wb_dat = 32'd0;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.o_wb_ack !== ((i % 2) == 0)) begin
        failures++; $display("FAIL b2b_ack cycle=%0d got=%b required=%b", i, bus.o_wb_ack, (i % 2) == 0);
      end
      if (bus.o_wb_ack === 1'b1) begin
        checks++;
        if (bus.o_wb_rdt !== 32'h31) begin
          failures++; $display("FAIL b2b_rdt cycle=%0d got=%h required=31", i, bus.o_wb_rdt);
        end
      end
    end
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_edge_rise();
    logic [31:0] r;
    bus_xfer(GPIO_RISE_EN, 1'b1, 32'h08, r);
    bus_xfer(GPIO_STATUS, 1'b1, 32'hFF, r);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rise_pre_irq got=%b required=0", irq); end
    pins[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k >= 3) begin
        checks++;
        if (irq !== (k == 4)) begin failures++; $display("FAIL rise_latency clk=%0d irq=%b required=%b", k, irq, k == 4); end
      end
    end
    bus_xfer(GPIO_STATUS, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h08) begin failures++; $display("FAIL rise_status got=%h required=08", r); end
    pins[3] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus_xfer(GPIO_STATUS, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h08) begin failures++; $display("FAIL fall_disabled got=%h required=08", r); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] r;
    pins[3] = 1'b1;
    @(posedge clk); #1;
    bus_xfer(GPIO_STATUS, 1'b1, 32'h08, r);
    bus_xfer(GPIO_STATUS, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h08) begin failures++; $display("FAIL w1c_set_wins got=%h required=08", r); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_held got=%b required=1", irq); end
    bus_xfer(GPIO_STATUS, 1'b1, 32'h08, r);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_lag got=%b required=1", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_clear got=%b required=0", irq); end
    bus_xfer(GPIO_STATUS, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL w1c_status got=%h required=0", r); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    int acks;
    bus_xfer(GPIO_OE, 1'b1, 32'h0F, r);
    bus_xfer(GPIO_OUT, 1'b1, 32'h00, r);
    checks++; if (gpio !== 8'h00) begin failures++; $display("FAIL areset_pre_out got=%h required=00", gpio); end
    bus.i_wb_adr = GPIO_OUT; bus.i_wb_we = 1'b1; bus.i_wb_dat = 32'h5A;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (gpio !== 8'hFF) begin failures++; $display("FAIL areset_out_immediate got=%h required=ff", gpio); end
    checks++; if (gpio_oe !== 8'h00) begin failures++; $display("FAIL areset_oe got=%h required=00", gpio_oe); end
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    #1 rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.o_wb_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL areset_no_ack got=%0d required=0", acks); end
    checks++; if (gpio !== 8'hFF) begin failures++; $display("FAIL areset_write_dropped got=%h required=ff", gpio); end
  endtask

  task automatic test_random();
    logic [31:0] r, d;
    logic [2:0]  a;
    logic [W-1:0] nw;
    int op;
    rst = 1'b1;
    pins = W'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    m_out = '1; m_oe = '0; m_rise = '0; m_fall = '0; m_status = '0; m_in = pins;
    repeat (SS + 2) @(posedge clk);
    #1;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      d = $urandom;
      case (op)
        0: begin bus_xfer(GPIO_OUT, 1'b1, d, r);      m_out = d[W-1:0]; end
        1: begin bus_xfer(GPIO_OE, 1'b1, d, r);       m_oe = d[W-1:0]; end
        2: begin bus_xfer(GPIO_RISE_EN, 1'b1, d, r);  m_rise = d[W-1:0]; end
        3: begin bus_xfer(GPIO_FALL_EN, 1'b1, d, r);  m_fall = d[W-1:0]; end
        4: begin bus_xfer(GPIO_STATUS, 1'b1, d, r);   m_status = m_status & ~d[W-1:0]; end
        5: begin bus_xfer(GPIO_OUT_SET, 1'b1, d, r);  m_out = m_out | d[W-1:0]; end
        6: begin bus_xfer(GPIO_OUT_CLR, 1'b1, d, r);  m_out = m_out & ~d[W-1:0]; end
        7, 8: begin
          nw = W'($urandom);
          m_status = m_status | (nw & ~m_in & m_rise) | (~nw & m_in & m_fall);
          m_in = nw;
          pins = nw;
          repeat (SS + 2) @(posedge clk);
          #1;
        end
        default: begin
          a = 3'($urandom_range(0, 7));
          bus_xfer(a, 1'b0, 32'd0, r);
          checks++;
          if (r !== exp_rd(a)) begin failures++; $display("FAIL rand_read it=%0d adr=%0d got=%h required=%h", it, a, r, exp_rd(a)); end
        end
      endcase
      @(posedge clk); #1;
      checks++;
      if (gpio !== m_out || gpio_oe !== m_oe || irq !== (|m_status)) begin
        failures++;
        $display("FAIL rand_pins it=%0d out=%h oe=%h irq=%b required out=%h oe=%h irq=%b",
                 it, gpio, gpio_oe, irq, m_out, m_oe, |m_status);
      end
    end
    for (int i = 0; i < 8; i++) begin
      bus_xfer(3'(i), 1'b0, 32'd0, r);
      checks++;
      if (r !== exp_rd(3'(i))) begin failures++; $display("FAIL rand_final adr=%0d got=%h required=%h", i, r, exp_rd(3'(i))); end
    end
  endtask

  task automatic test_width1();
    logic [31:0] r;
    logic [7:0]  byte_v;
    logic [9:0]  frame;
    int bad;
    bus1_xfer(GPIO_OUT, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL w1_reset_out got=%h required=1", r); end
    bus1_xfer(GPIO_OUT, 1'b1, 32'hFFFF_FFFE, r);
    bus1_xfer(GPIO_OUT, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL w1_upper_ignored got=%h required=0", r); end
    bus1_xfer(GPIO_OUT_SET, 1'b1, 32'hFFFF_FFFF, r);
    bus1_xfer(GPIO_OUT, 1'b0, 32'd0, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL w1_out_set got=%h required=1", r); end
    byte_v = 8'($urandom);
    frame = {1'b1, byte_v, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (frame[b]) bus1_xfer(GPIO_OUT_SET, 1'b1, 32'h1, r);
      else          bus1_xfer(GPIO_OUT_CLR, 1'b1, 32'h1, r);
      bad = 0;
      for (int c = 0; c < BIT_CYC - 2; c++) begin
        if (gpio1[0] !== frame[b]) bad++;
        @(posedge clk); #1;
      end
      checks++;
      if (bad != 0 || gpio1[0] !== frame[b]) begin
        failures++; $display("FAIL w1_uart_bit idx=%0d got=%b required=%b bad_cycles=%0d", b, gpio1[0], frame[b], bad);
      end
    end
    checks++; if (gpio1_oe !== 1'b0 || irq1 !== 1'b0) begin
      failures++; $display("FAIL w1_oe_irq oe=%b irq=%b required=0", gpio1_oe, irq1);
    end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_back_to_back();
    test_edge_rise();
    test_w1c_collision();
    test_async_reset();
    test_random();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servant_gpio_bank.md
Name: servant_gpio_bank

Overview:
Parametrised successor to the single-bit servant GPIO that drives the bit-banged UART line (q) on board tops such as the Nexys 4 wrapper.
Wishbone slave with WIDTH independent pins, each with:
- output register
- output-enable register
- synchronised input
- rising/falling edge detection with a maskable level interrupt
Sits on the servant peripheral bus. Board tops route bit 0 to the UART TX pin, keeping software compatibility for that line.

Parameters:
WIDTH, 8, number of GPIO channels, 1..32
SYNC_STAGES, 2, input synchroniser flops per channel, >=2
OUT_RESET, 1, reset value of every bit of the OUT register (idle-high UART line)

Ports:
wb_clk  input  1  system clock
wb_rst  input  1  reset, asynchronous, active-high
i_wb_adr  input  3  word address (bus bits [4:2])
i_wb_dat  input  32  write data
i_wb_we  input  1  write enable
i_wb_cyc  input  1  bus cycle
i_wb_stb  input  1  strobe
o_wb_rdt  output  32  read data
o_wb_ack  output  1  acknowledge
i_gpio  input  WIDTH  asynchronous pin inputs
o_gpio  output  WIDTH  pin output values (OUT register)
o_gpio_oe  output  WIDTH  pin output enables
o_irq  output  1  interrupt, level

Behaviour:
Register map (word address):
- 0 OUT: read/write.
- 1 OE: read/write.
- 2 IN: read-only, synchronised pin values; writes ignored.
- 3 RISE_EN: read/write.
- 4 FALL_EN: read/write.
- 5 STATUS: read; write-1-to-clear.
- 6 OUT_SET: write ORs data into OUT; reads 0.
- 7 OUT_CLR: write clears OUT bits where data is 1; reads 0.

Data width rules:
- Register bits [WIDTH-1:0] are significant.
- Bits [31:WIDTH] read 0 and are ignored on write.
- Full-word writes only; no byte selects.

Wishbone handshake:
- o_wb_ack asserts one cycle after i_wb_cyc & i_wb_stb with o_wb_ack low.
- o_wb_ack is high for exactly one cycle, then low for at least one cycle (max one access per two cycles).
- Write takes effect on the ack cycle edge; the register is visible the cycle after ack.
- o_wb_rdt is registered, valid while o_wb_ack is high, and 0 otherwise.

Input synchroniser:
- i_gpio passes through a SYNC_STAGES flop chain to give sync, plus one further flop to give prev.
- IN reads sync.

Edge detection:
- rise = sync & ~prev; fall = ~sync & prev.
- STATUS[i] sets on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- STATUS is sticky until cleared.
- Latency from an i_gpio change to STATUS set is SYNC_STAGES+1 clocks.

Interrupt:
- o_irq is the register output of |STATUS, so it goes high one cycle after STATUS sets.
- There is no separate mask: disabling an edge enable stops new events but does not clear already-set bits.

Simultaneous events:
- A W1C to STATUS[i] in the same cycle a new qualifying edge on bit i arrives leaves STATUS[i] set (set wins).
- OUT_SET/OUT_CLR are single-cycle read-modify-write, with no hazard against a bus write in the same cycle (only one access can be acked per cycle).

Reset (asynchronous, any time, including mid-access):
- OUT = {WIDTH{OUT_RESET}}; OE = 0; RISE_EN = 0; FALL_EN = 0; STATUS = 0.
- Synchroniser and prev flops = 0.
- o_wb_ack = 0; o_wb_rdt = 0; o_irq = 0.
- An access interrupted by reset is never acked; the master must re-issue.
- Edge logic must not flag a rise during the first cycles after reset release from the zeroed synchroniser. Prev is loaded from sync, with detection gated until the chain has filled (SYNC_STAGES+1-cycle arm counter).

Decomposition:
- Shared package servant_gpio_pkg holds the register address constants (GPIO_OUT=0 .. GPIO_OUT_CLR=7) and the ack/read-data width constant 32.
- One natural sub-module: servant_gpio_sync, a per-bus WIDTH×SYNC_STAGES synchroniser with async reset, instantiated once.
- Register file, edge logic and bus FSM stay in the top.

Test Plan:
1. Reset release, WIDTH=8 -> o_gpio=8'hFF, o_gpio_oe=0, o_irq=0; read of addr 2 with i_gpio=8'hA5 steady returns 32'h000000A5; STATUS reads 0 (no spurious edges).
2. Bus writes: write OUT=32'hFFFF_FF3C -> read back 32'h0000003C. Write OUT_SET=0x01 -> 0x3D. Write OUT_CLR=0x0C -> 0x31. Ack is one cycle wide, and back-to-back strobes see ack every second cycle.
3. Rising edge on bit 3: RISE_EN=0x08, i_gpio[3] 0->1 -> STATUS=0x08 exactly 3 clocks later and o_irq high 1 clock after that. A falling edge on bit 3 with FALL_EN=0 leaves STATUS unchanged.
4. W1C collision: STATUS=0x08; write 0x08 to addr 5 in the same cycle a new rising edge on bit 3 qualifies -> STATUS remains 0x08 and o_irq stays high. A later write of 0x08 with no edge -> STATUS=0, o_irq low next cycle.
5. Asynchronous reset mid-write (wb_rst pulsed between stb and ack) -> no ack issued; OUT returns to 0xFF immediately, without waiting for a clock edge.
6. WIDTH=1 build -> only bit 0 significant; reads of addr 0 return 32'h1 after reset; o_gpio toggling via OUT_SET/OUT_CLR reproduces a bit-banged UART frame at the programmed timing.
